// File: rtl/fifo_pkg.sv
// Shared FIFO definitions used by both the read-side controller and the write side.
// Pointer and level types are sized from the default address width.
package fifo_pkg;

    localparam int ADDR_WIDTH = 9;
    localparam int DATA_WIDTH = 8;
    localparam int DEPTH      = 1 << ADDR_WIDTH;

    // Pointers carry one wrap bit above the RAM address so full and empty differ.
    typedef logic [ADDR_WIDTH:0]   ptr_t;
    typedef logic [ADDR_WIDTH+1:0] level_t;

    // Occupancy of the two-entry output buffer; the encoding is also the word count.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_t;

endpackage

// File: rtl/fifo_out_skid.sv
// Two-entry first-word-fall-through output buffer (head + skid register).
// The upstream read logic never offers a word when both entries are occupied and no pop occurs.
module fifo_out_skid #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            count
);
    import fifo_pkg::*;

    buf_state_t            state_q;
    buf_state_t            state_d;
    logic [DATA_WIDTH-1:0] head_q;
    logic [DATA_WIDTH-1:0] skid_q;
    logic                  pop;
    logic                  head_load_in;
    logic                  head_load_skid;
    logic                  skid_load;

    assign out_valid = (state_q != BUF_EMPTY);
    assign out_data  = head_q;
    assign count     = state_q;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BUF_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            skid_q <= '0;
        end else begin
            if (head_load_in) begin
                head_q <= in_data;
            end else if (head_load_skid) begin
                head_q <= skid_q;
            end
            if (skid_load) begin
                skid_q <= in_data;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        head_load_in   = 1'b0;
        head_load_skid = 1'b0;
        skid_load      = 1'b0;
        case (state_q)
            BUF_EMPTY: begin
                if (in_valid) begin
                    head_load_in = 1'b1;
                    state_d      = BUF_ONE;
                end
            end
            BUF_ONE: begin
                // A word arriving while the head leaves replaces it directly.
                case ({pop, in_valid})
                    2'b11: head_load_in = 1'b1;
                    2'b10: state_d = BUF_EMPTY;
                    2'b01: begin
                        skid_load = 1'b1;
                        state_d   = BUF_TWO;
                    end
                    default: state_d = BUF_ONE;
                endcase
            end
            BUF_TWO: begin
                if (pop) begin
                    head_load_skid = 1'b1;
                    if (in_valid) begin
                        skid_load = 1'b1;
                    end else begin
                        state_d = BUF_ONE;
                    end
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
    end

    no_overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(state_q == BUF_TWO && in_valid && !pop));

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller: compares pointers, issues reads to the 1-cycle synchronous RAM
// and presents the words as a first-word-fall-through stream.
module fifo_rd_ctrl #(
    parameter int ADDR_WIDTH = fifo_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH:0]   wr_ptr,
    output logic [ADDR_WIDTH:0]   rd_ptr,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  empty,
    output logic [ADDR_WIDTH+1:0] level
);

    // Stream handshake: a word transfers on a rising edge where dout_valid and dout_ready
    // are both high; once raised, dout_valid and dout hold until that transfer, and
    // dout_ready is ignored while dout_valid is low.

    logic [ADDR_WIDTH:0] rd_ptr_q;
    logic [ADDR_WIDTH:0] ram_used;
    logic                inflight_q;
    logic                ram_empty;
    logic                pop;
    logic [1:0]          buf_cnt;
    logic [2:0]          occ_after;

    assign ram_empty = (wr_ptr == rd_ptr_q);
    assign pop       = dout_valid & dout_ready;

    // Words that will be buffered or returning after this edge; a new read is issued only
    // if the buffer still has room for it when it comes back.
    assign occ_after = {1'b0, buf_cnt} + {2'b00, inflight_q} - {2'b00, pop};
    assign mem_rd_en = ~ram_empty & (occ_after < 3'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= mem_rd_en;
            if (mem_rd_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    fifo_out_skid #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (inflight_q),
        .in_data  (mem_rd_data),
        .out_ready(dout_ready),
        .out_valid(dout_valid),
        .out_data (dout),
        .count    (buf_cnt)
    );

    assign rd_ptr      = rd_ptr_q;
    assign mem_rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];
    assign empty       = ~dout_valid;

    // Natural modulo subtraction gives 2**ADDR_WIDTH when the RAM is full.
    assign ram_used = wr_ptr - rd_ptr_q;
    assign level    = {1'b0, ram_used}
                    + {{(ADDR_WIDTH+1){1'b0}}, inflight_q}
                    + {{ADDR_WIDTH{1'b0}}, buf_cnt};

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: vector table, hand-written corner sequences and randomized traffic
// scored against a queue of words written but not yet consumed.
module tb_fifo_rd_ctrl;
    import fifo_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_n;
    ptr_t                  wr_ptr;
    ptr_t                  rd_ptr;
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_rd_addr;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_valid;
    logic                  dout_ready;
    logic                  empty;
    level_t                level;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] exp_q[$];

    int   tests = 0;
    int   fails = 0;
    logic prev_stall;
    logic [DATA_WIDTH-1:0] prev_dout;
    ptr_t prev_rd_ptr;
    int   wraps;
    int   max_level;

    typedef struct {
        logic                  wr;
        logic                  rdy;
        logic                  exp_rd_en;
        logic                  exp_valid;
        logic [DATA_WIDTH-1:0] exp_dout;
        int                    exp_level;
        int                    exp_rd_ptr;
    } vec_t;

    vec_t vecs[16];

    fifo_rd_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_ptr     (wr_ptr),
        .rd_ptr     (rd_ptr),
        .mem_rd_en  (mem_rd_en),
        .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .empty      (empty),
        .level      (level)
    );

    // Clock and synchronous RAM with one cycle of read latency.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic wr, input logic rdy, input logic rd_en, input logic valid,
                                input logic [DATA_WIDTH-1:0] d, input int lvl, input int rp);
        vec_t v;
        v.wr = wr; v.rdy = rdy; v.exp_rd_en = rd_en; v.exp_valid = valid;
        v.exp_dout = d; v.exp_level = lvl; v.exp_rd_ptr = rp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Write side: store the word in the RAM model and advance the write pointer.
    task automatic push_word(input logic [DATA_WIDTH-1:0] d);
        mem[wr_ptr[ADDR_WIDTH-1:0]] = d;
        exp_q.push_back(d);
        wr_ptr = wr_ptr + 1'b1;
    endtask

    task automatic check_cycle();
        check("level_vs_model", 32'(level), 32'(exp_q.size()));
        if (int'(level) > max_level) max_level = int'(level);
        if (rd_ptr < prev_rd_ptr) wraps++;
        prev_rd_ptr = rd_ptr;
        if (prev_stall) begin
            check("stall_valid", 32'(dout_valid), 32'd1);
            check("stall_data", 32'(dout), 32'(prev_dout));
        end
        if (dout_valid && dout_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL pop_extra: got word 0x%0h, want no word", dout);
            end else begin
                check("dout_order", 32'(dout), 32'(exp_q.pop_front()));
            end
        end
        prev_stall = dout_valid & ~dout_ready;
        prev_dout  = dout;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        wr_ptr     = '0;
        dout_ready = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        prev_stall = 1'b0;
    endtask

    task automatic run_random(input int n_words, input int wr_pct, input int rdy_pct);
        int written = 0;
        int cycles  = 0;
        int budget  = n_words * 10 + 3000;
        prev_stall  = 1'b0;
        prev_rd_ptr = rd_ptr;
        while ((written < n_words || exp_q.size() != 0) && cycles < budget) begin
            @(negedge clk);
            if (written < n_words && int'($urandom_range(99)) < wr_pct &&
                ptr_t'(wr_ptr - rd_ptr) != ptr_t'(DEPTH)) begin
                push_word(DATA_WIDTH'($urandom_range(255)));
                written++;
            end
            if (written < n_words) dout_ready = (int'($urandom_range(99)) < rdy_pct);
            else                   dout_ready = (int'($urandom_range(99)) < 85);
            #1;
            check_cycle();
            cycles++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_stream(input int n_words);
        prev_stall  = 1'b0;
        prev_rd_ptr = rd_ptr;
        for (int i = 0; i < n_words + 2; i++) begin
            @(negedge clk);
            if (i < n_words) push_word(DATA_WIDTH'($urandom_range(255)));
            dout_ready = 1'b1;
            #1;
            if (i >= 2) check($sformatf("stream_valid%0d", i), 32'(dout_valid), 32'd1);
            check_cycle();
        end
        check("stream_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [DATA_WIDTH-1:0] data_ctr;

        // Single word then backpressure on five words, released one per cycle.
        vecs[0]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1, 0);
        vecs[1]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1, 1);
        vecs[2]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 8'hA0, 1, 1);
        vecs[3]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1);
        vecs[4]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1, 1);
        vecs[5]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2, 2);
        vecs[6]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 8'hA1, 3, 3);
        vecs[7]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 8'hA1, 4, 3);
        vecs[8]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 8'hA1, 5, 3);
        vecs[9]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 8'hA1, 5, 3);
        vecs[10] = mk(1'b0, 1'b1, 1'b1, 1'b1, 8'hA1, 5, 3);
        vecs[11] = mk(1'b0, 1'b1, 1'b1, 1'b1, 8'hA2, 4, 4);
        vecs[12] = mk(1'b0, 1'b1, 1'b1, 1'b1, 8'hA3, 3, 5);
        vecs[13] = mk(1'b0, 1'b1, 1'b0, 1'b1, 8'hA4, 2, 6);
        vecs[14] = mk(1'b0, 1'b1, 1'b0, 1'b1, 8'hA5, 1, 6);
        vecs[15] = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 0, 6);

        rst_n      = 1'b0;
        wr_ptr     = '0;
        dout_ready = 1'b0;
        wraps      = 0;
        max_level  = 0;
        prev_stall = 1'b0;
        data_ctr   = 8'hA0;

        @(negedge clk);
        #1;
        check("reset_rd_ptr", 32'(rd_ptr), 32'd0);
        check("reset_dout", 32'(dout), 32'd0);
        check("reset_valid", 32'(dout_valid), 32'd0);
        check("reset_empty", 32'(empty), 32'd1);
        check("reset_level", 32'(level), 32'd0);
        check("reset_rd_en", 32'(mem_rd_en), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (vecs[i].wr) begin
                push_word(data_ctr);
                data_ctr = data_ctr + 1'b1;
            end
            dout_ready = vecs[i].rdy;
            #1;
            check($sformatf("vec%0d_rd_en", i), 32'(mem_rd_en), 32'(vecs[i].exp_rd_en));
            check($sformatf("vec%0d_valid", i), 32'(dout_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_empty", i), 32'(empty), 32'(!vecs[i].exp_valid));
            check($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].exp_level));
            check($sformatf("vec%0d_rd_ptr", i), 32'(rd_ptr), 32'(vecs[i].exp_rd_ptr));
            if (vecs[i].exp_valid) check($sformatf("vec%0d_dout", i), 32'(dout), 32'(vecs[i].exp_dout));
            if (dout_valid && dout_ready && exp_q.size() > 0) void'(exp_q.pop_front());
        end

        // Reset in the middle of a backpressured stream discards everything.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i < 3) push_word(8'h30 + 8'(i));
            dout_ready = 1'b0;
        end
        #1;
        check("mid_valid_before_rst", 32'(dout_valid), 32'd1);
        check("mid_level_before_rst", 32'(level), 32'd3);
        @(negedge clk);
        rst_n      = 1'b0;
        wr_ptr     = '0;
        dout_ready = 1'b1;
        exp_q.delete();
        #1;
        check("mid_rst_rd_ptr", 32'(rd_ptr), 32'd0);
        check("mid_rst_valid", 32'(dout_valid), 32'd0);
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_rd_en", 32'(mem_rd_en), 32'd0);
        @(negedge clk);
        #1;
        check("mid_rst_held_valid", 32'(dout_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_stream(40);

        // Full RAM: pointers differ by the depth, reads must still go out.
        do_reset();
        @(negedge clk);
        for (int i = 0; i < DEPTH; i++) push_word(DATA_WIDTH'(i * 7 + 3));
        dout_ready = 1'b0;
        #1;
        check("full_rd_en", 32'(mem_rd_en), 32'd1);
        check("full_level", 32'(level), 32'(DEPTH));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
        end
        #1;
        check("full_stall_rd_en", 32'(mem_rd_en), 32'd0);
        check("full_stall_rd_ptr", 32'(rd_ptr), 32'd2);
        check("full_stall_level", 32'(level), 32'(DEPTH));
        check("full_stall_dout", 32'(dout), 32'd3);
        run_random(0, 0, 0);

        // Bring both pointers to 0x3FF, then cross the wrap with a single word.
        @(negedge clk);
        for (int i = 0; i < DEPTH - 1; i++) push_word(DATA_WIDTH'($urandom_range(255)));
        run_random(0, 0, 0);
        @(negedge clk);
        dout_ready = 1'b1;
        #1;
        check("edge_rd_ptr", 32'(rd_ptr), 32'h3FF);
        check("edge_no_read", 32'(mem_rd_en), 32'd0);
        check("edge_level", 32'(level), 32'd0);
        @(negedge clk);
        push_word(8'h5C);
        #1;
        check("wrap_rd_en", 32'(mem_rd_en), 32'd1);
        check("wrap_addr_hi", 32'(mem_rd_addr), 32'h1FF);
        @(negedge clk);
        #1;
        check("wrap_rd_ptr", 32'(rd_ptr), 32'd0);
        check("wrap_addr_lo", 32'(mem_rd_addr), 32'd0);
        check("wrap_valid_early", 32'(dout_valid), 32'd0);
        @(negedge clk);
        #1;
        check("wrap_valid", 32'(dout_valid), 32'd1);
        check("wrap_dout", 32'(dout), 32'h5C);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        @(negedge clk);
        #1;
        check("wrap_level_after", 32'(level), 32'd0);

        // Long random run: pointers wrap at least twice.
        do_reset();
        wraps     = 0;
        max_level = 0;
        run_random(2100, 75, 45);
        check("wrap_count_ok", 32'(wraps >= 2), 32'd1);
        check("level_bound_ok", 32'(max_level <= DEPTH + 2), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
